// File: rtl/lsu64_byteserial.sv
// Byte-serial load/store unit in front of the 64-bit data memory port.
// Loads gather one byte per cycle; sub-word stores do read-modify-write.
module lsu64_byteserial #(
   parameter int unsigned MEM_BYTES = 524288,
   parameter int          ADDR_W    = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [63:0]       req_wdata,
   output logic              resp_valid,
   output logic [63:0]       resp_rdata,
   output logic              resp_err,
   output logic [2:0]        dm_rd_ctrl,
   output logic [1:0]        dm_wr_ctrl,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [63:0]       dm_din,
   input  logic [63:0]       dm_dout
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_nx;
   logic [ADDR_W-1:0]   r_addr;
   logic [1:0]          r_size;
   logic                r_we;
   logic                r_uns;
   logic [63:0]         r_wdata;
   logic [2:0]          r_cnt;
   logic [63:0]         r_buf;
   logic [63:0]         r_rdata;
   logic                r_err;

   logic [3:0]          w_nbytes;
   logic [ADDR_W:0]     w_end;
   logic                w_oor;
   logic [2:0]          w_rd_last;
   logic                w_wr_last;
   logic [63:0]         w_buf_nx;
   logic [63:0]         w_ld;
   logic [31:0]         w_wword;
   logic                w_unused;

   assign w_unused = ^dm_dout[63:8];

   // Sub-word stores are range-checked as the 4-byte word they rewrite.
   always_comb begin
      w_nbytes = 4'd1;
      unique case (req_size)
         2'd0: w_nbytes = req_we ? 4'd4 : 4'd1;
         2'd1: w_nbytes = req_we ? 4'd4 : 4'd2;
         2'd2: w_nbytes = 4'd4;
         2'd3: w_nbytes = 4'd8;
      endcase
   end

   assign w_end = {1'b0, req_addr} + (ADDR_W+1)'(w_nbytes);
   assign w_oor = w_end > (ADDR_W+1)'(MEM_BYTES);

   always_comb begin
      w_rd_last = 3'd0;
      unique case (r_size)
         2'd0: w_rd_last = r_we ? 3'd3 : 3'd0;
         2'd1: w_rd_last = r_we ? 3'd3 : 3'd1;
         2'd2: w_rd_last = 3'd3;
         2'd3: w_rd_last = 3'd7;
      endcase
   end

   assign w_wr_last = (r_size != 2'd3) || r_cnt[0];

   always_comb begin
      w_buf_nx = r_buf;
      w_buf_nx[{r_cnt, 3'b000} +: 8] = dm_dout[7:0];
   end

   always_comb begin
      w_ld = w_buf_nx;
      unique case (r_size)
         2'd0: w_ld = {{56{w_buf_nx[7]  & ~r_uns}}, w_buf_nx[7:0]};
         2'd1: w_ld = {{48{w_buf_nx[15] & ~r_uns}}, w_buf_nx[15:0]};
         2'd2: w_ld = {{32{w_buf_nx[31] & ~r_uns}}, w_buf_nx[31:0]};
         2'd3: w_ld = w_buf_nx;
      endcase
   end

   always_comb begin
      w_wword = r_wdata[31:0];
      unique case (r_size)
         2'd0: w_wword = {r_buf[31:8],  r_wdata[7:0]};
         2'd1: w_wword = {r_buf[31:16], r_wdata[15:0]};
         2'd2: w_wword = r_wdata[31:0];
         2'd3: w_wword = r_cnt[0] ? r_wdata[63:32] : r_wdata[31:0];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      dm_rd_ctrl = 3'b000;
      dm_wr_ctrl = 2'b00;
      dm_addr    = '0;
      dm_din     = '0;
      unique case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_oor)
                  w_state_nx = S_DONE;
               else if (req_we && req_size[1])
                  w_state_nx = S_WR;
               else
                  w_state_nx = S_RD;
            end
         end
         S_RD: begin
            dm_rd_ctrl = 3'b010;
            dm_addr    = r_addr + ADDR_W'(r_cnt);
            if (r_cnt == w_rd_last)
               w_state_nx = r_we ? S_WR : S_DONE;
         end
         S_WR: begin
            dm_wr_ctrl = 2'b11;
            dm_addr    = r_addr + (r_cnt[0] ? ADDR_W'(4) : '0);
            dm_din     = {32'b0, w_wword};
            if (w_wr_last)
               w_state_nx = S_DONE;
         end
         S_DONE: w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_size  <= 2'd0;
         r_we    <= 1'b0;
         r_uns   <= 1'b0;
         r_wdata <= '0;
         r_cnt   <= 3'd0;
         r_buf   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         if (r_state == S_IDLE && req_valid) begin
            r_addr  <= req_addr;
            r_size  <= req_size;
            r_we    <= req_we;
            r_uns   <= req_unsigned;
            r_wdata <= req_wdata;
            r_cnt   <= 3'd0;
            r_buf   <= '0;
         end
         if (r_state == S_RD) begin
            r_buf <= w_buf_nx;
            r_cnt <= (r_cnt == w_rd_last) ? 3'd0 : r_cnt + 3'd1;
         end
         if (r_state == S_WR)
            r_cnt <= r_cnt + 3'd1;
         // Result registers change only on entry to DONE and hold after.
         if (w_state_nx == S_DONE && r_state != S_DONE) begin
            r_rdata <= (r_state == S_RD && !r_we) ? w_ld : '0;
            r_err   <= (r_state == S_IDLE);
         end
      end
   end

   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = (r_state == S_DONE);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule
